// File: rtl/array_mul_ctrl.sv
// Operand-issue / result-capture controller wrapped around the 32x32 array multiplier.
// Optional request tagging is compiled in with ARRAY_MUL_CTRL_TAG_EN.
module array_mul_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef ARRAY_MUL_CTRL_TAG_EN
  input  logic [TAG_W-1:0]         in_tag,
  output logic [TAG_W-1:0]         out_tag,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_mcand,
  input  logic [31:0]              in_mlier,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_prodt,
  output logic [31:0]              mul_mcand,
  output logic [31:0]              mul_mlier,
  output logic                     mul_start,
  input  logic [63:0]              mul_prodt,
  input  logic                     mul_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LCNT_W = $clog2(LAT + 1);
`ifdef ARRAY_MUL_CTRL_TAG_EN
  localparam int unsigned ENT_W  = 64 + TAG_W;
`else
  localparam int unsigned ENT_W  = 64 + 0 * TAG_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT} state_e;

  state_e              state_q, state_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [ENT_W-1:0]    head_c;
  logic [31:0]         mcand_q, mcand_d, mlier_q, mlier_d;
  logic                start_q, start_d;
  logic                ovalid_q, ovalid_d;
  logic [63:0]         oprodt_q, oprodt_d;
  logic                busy_q, busy_d;
  logic                push_c, pop_c, capt_c;
`ifdef ARRAY_MUL_CTRL_TAG_EN
  logic [TAG_W-1:0]    tpend_q, tpend_d, otag_q, otag_d;
`endif

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign push_c    = in_valid && in_ready;
  // Issue only when the result slot is free or is being drained this cycle.
  assign pop_c     = (state_q == S_IDLE) && (count_q != '0) && (!ovalid_q || out_ready);
  assign capt_c    = (state_q == S_CAPT) && mul_valid;
  assign head_c    = mem_q[rd_ptr_q];

  assign mul_mcand = mcand_q;
  assign mul_mlier = mlier_q;
  assign mul_start = start_q;
  assign out_valid = ovalid_q;
  assign out_prodt = oprodt_q;
  assign busy      = busy_q;
  assign count     = count_q;
`ifdef ARRAY_MUL_CTRL_TAG_EN
  assign out_tag   = otag_q;
`endif

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lcnt_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mcand_q  <= '0;
      mlier_q  <= '0;
      start_q  <= 1'b0;
      ovalid_q <= 1'b0;
      oprodt_q <= '0;
      busy_q   <= 1'b0;
`ifdef ARRAY_MUL_CTRL_TAG_EN
      tpend_q  <= '0;
      otag_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mcand_q  <= mcand_d;
      mlier_q  <= mlier_d;
      start_q  <= start_d;
      ovalid_q <= ovalid_d;
      oprodt_q <= oprodt_d;
      busy_q   <= busy_d;
`ifdef ARRAY_MUL_CTRL_TAG_EN
      tpend_q  <= tpend_d;
      otag_q   <= otag_d;
`endif
    end
  end

  // Operand storage; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clock) begin
    if (push_c) begin
`ifdef ARRAY_MUL_CTRL_TAG_EN
      mem_q[wr_ptr_q] <= {in_tag, in_mlier, in_mcand};
`else
      mem_q[wr_ptr_q] <= {in_mlier, in_mcand};
`endif
    end
  end

  // WAIT spans the edge where the multiplier samples start plus LAT cycles.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          state_d = S_WAIT;
          lcnt_d  = LCNT_W'(LAT);
        end
      end
      S_WAIT: begin
        if (lcnt_q == '0) state_d = S_CAPT;
        else              lcnt_d  = lcnt_q - LCNT_W'(1);
      end
      S_CAPT: begin
        if (mul_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, operand issue and result capture.
  always_comb begin
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mcand_d  = mcand_q;
    mlier_d  = mlier_q;
    start_d  = pop_c;
    ovalid_d = ovalid_q && !out_ready;
    oprodt_d = oprodt_q;
    busy_d   = (state_d != S_IDLE);
`ifdef ARRAY_MUL_CTRL_TAG_EN
    tpend_d  = tpend_q;
    otag_d   = otag_q;
`endif
    if (pop_c) begin
      mcand_d = head_c[31:0];
      mlier_d = head_c[63:32];
`ifdef ARRAY_MUL_CTRL_TAG_EN
      tpend_d = head_c[ENT_W-1:64];
`endif
    end
    if (capt_c) begin
      ovalid_d = 1'b1;
      oprodt_d = mul_prodt;
`ifdef ARRAY_MUL_CTRL_TAG_EN
      otag_d   = tpend_q;
`endif
    end
  end

endmodule

// File: tb/tb_array_mul_ctrl.sv
// Directed bench for array_mul_ctrl with a one-cycle registered multiplier model (LAT=1).
// Tag checks are compiled only when ARRAY_MUL_CTRL_TAG_EN is defined.
module tb_array_mul_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned TAG_W = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        mv = 1'b1;
  logic [31:0] in_mcand = '0;
  logic [31:0] in_mlier = '0;
  logic        in_ready, out_valid, mul_start, busy, mul_valid;
  logic [63:0] out_prodt, mul_prodt;
  logic [31:0] mul_mcand, mul_mlier;
  logic [2:0]  count;
`ifdef ARRAY_MUL_CTRL_TAG_EN
  logic [TAG_W-1:0] in_tag = '0;
  logic [TAG_W-1:0] out_tag;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  array_mul_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef ARRAY_MUL_CTRL_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mcand  (in_mcand),
    .in_mlier  (in_mlier),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prodt (out_prodt),
    .mul_mcand (mul_mcand),
    .mul_mlier (mul_mlier),
    .mul_start (mul_start),
    .mul_prodt (mul_prodt),
    .mul_valid (mul_valid),
    .busy      (busy),
    .count     (count)
  );

  // Multiplier model: product register loads on the edge that samples start.
  always @(posedge clock or negedge reset) begin
    if (!reset) mul_prodt <= '0;
    else if (mul_start) mul_prodt <= 64'(mul_mcand) * 64'(mul_mlier);
  end
  assign mul_valid = mv & reset;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b);
    in_mcand = a;
    in_mlier = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #2;
    total++;
    if ({in_ready, count, out_valid, busy, mul_start} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=%b", {in_ready, count, out_valid, busy, mul_start}, 7'b1000000);
    end
    total++;
    if ({out_prodt, mul_mcand, mul_mlier} !== 128'd0) begin
      bad++;
      $display("FAIL reset_data got prodt=%h mcand=%h mlier=%h want all zero", out_prodt, mul_mcand, mul_mlier);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push_one(32'd3, 32'd5);
    total++;
    if ({count, busy, mul_start} !== {3'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_a got count=%0d busy=%b start=%b want 1 0 0", count, busy, mul_start);
    end
    tick();
    total++;
    if ({mul_start, busy, count, mul_mcand, mul_mlier} !== {1'b1, 1'b1, 3'd0, 32'd3, 32'd5}) begin
      bad++;
      $display("FAIL single_issue got start=%b busy=%b count=%0d mcand=%0d mlier=%0d want 1 1 0 3 5",
               mul_start, busy, count, mul_mcand, mul_mlier);
    end
    tick();
    total++;
    if ({mul_start, mul_mcand} !== {1'b0, 32'd3}) begin
      bad++;
      $display("FAIL single_start_pulse got start=%b mcand=%0d want 0 3", mul_start, mul_mcand);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got out_valid=%b want 0", out_valid);
    end
    tick();
    total++;
    if ({out_valid, out_prodt} !== {1'b1, 64'h000000000000000F}) begin
      bad++;
      $display("FAIL single_result got valid=%b prodt=%h want 1 000000000000000f", out_valid, out_prodt);
    end
    tick();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_clear got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_max_operands();
    logic [63:0] exp [2];
    int got;
    exp[0] = 64'hFFFFFFFE00000001;
    exp[1] = 64'h0;
    out_ready = 1'b1;
    push_one(32'hFFFFFFFF, 32'hFFFFFFFF);
    push_one(32'h0, 32'h12345678);
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (out_valid) begin
        total++;
        if (out_prodt !== exp[got]) begin
          bad++;
          $display("FAIL max_result%0d got=%h want=%h", got, out_prodt, exp[got]);
        end
        got++;
      end
      tick();
    end
    total++;
    if (got != 2) begin
      bad++;
      $display("FAIL max_count got=%0d results want=2", got);
    end
  endtask

  task automatic test_stall();
    mv = 1'b0;
    out_ready = 1'b1;
    push_one(32'd6, 32'd7);
    repeat (10) tick();
    total++;
    if ({out_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL stall_hold got valid=%b busy=%b want 0 1", out_valid, busy);
    end
    mv = 1'b1;
    tick();
    total++;
    if ({out_valid, out_prodt} !== {1'b1, 64'd42}) begin
      bad++;
      $display("FAIL stall_release got valid=%b prodt=%0d want 1 42", out_valid, out_prodt);
    end
    tick();
  endtask

  task automatic test_full();
    logic [63:0] exp [6];
    int acc, got;
    logic take;
    exp[0] = 64'd200; exp[1] = 64'd303; exp[2] = 64'd408;
    exp[3] = 64'd515; exp[4] = 64'd624; exp[5] = 64'd735;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      in_mcand = 32'(acc + 2);
      in_mlier = 32'(acc + 100);
      in_valid = 1'b1;
      take = in_ready;
      tick();
      if (take) acc++;
    end
    total++;
    if ({acc[3:0], count, in_ready, out_valid} !== {4'd5, 3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL full_state got acc=%0d count=%0d in_ready=%b valid=%b want 5 4 0 1",
               acc, count, in_ready, out_valid);
    end
    repeat (3) tick();
    total++;
    if ({out_prodt, count} !== {64'd200, 3'd4}) begin
      bad++;
      $display("FAIL full_hold got prodt=%0d count=%0d want 200 4", out_prodt, count);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      if (out_valid) begin
        total++;
        if (out_prodt !== exp[got]) begin
          bad++;
          $display("FAIL full_order%0d got=%0d want=%0d", got, out_prodt, exp[got]);
        end
        got++;
      end
      take = in_valid && in_ready;
      tick();
      if (take) begin
        acc++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    total++;
    if ({got[3:0], acc[3:0], count} !== {4'd6, 4'd6, 3'd0}) begin
      bad++;
      $display("FAIL full_drain got results=%0d pushed=%0d count=%0d want 6 6 0", got, acc, count);
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] exp [5];
    int acc, got;
    logic take;
    exp[0] = 64'd231; exp[1] = 64'd264; exp[2] = 64'd299; exp[3] = 64'd336; exp[4] = 64'd375;
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 30 && acc < 5; c++) begin
      in_mcand = 32'(acc + 10);
      in_mlier = 32'(acc + 20);
      in_valid = 1'b1;
      take = in_ready;
      tick();
      if (take) acc++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    total++;
    if ({count, out_valid, busy, out_prodt} !== {3'd4, 1'b1, 1'b0, 64'd200}) begin
      bad++;
      $display("FAIL simul_setup got count=%0d valid=%b busy=%b prodt=%0d want 4 1 0 200",
               count, out_valid, busy, out_prodt);
    end
    in_mcand = 32'd15;
    in_mlier = 32'd25;
    in_valid = 1'b1;
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL simul_ready got in_ready=%b want 0", in_ready);
    end
    tick();
    total++;
    if ({count, mul_start, out_valid} !== {3'd3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL simul_pop got count=%0d start=%b valid=%b want 3 1 0", count, mul_start, out_valid);
    end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL simul_push got count=%0d want 4", count);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (out_valid) begin
        total++;
        if (out_prodt !== exp[got]) begin
          bad++;
          $display("FAIL simul_order%0d got=%0d want=%0d", got, out_prodt, exp[got]);
        end
        got++;
      end
      tick();
    end
    total++;
    if ({got[3:0], count} !== {4'd5, 3'd0}) begin
      bad++;
      $display("FAIL simul_drain got results=%0d count=%0d want 5 0", got, count);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    push_one(32'd11, 32'd13);
    push_one(32'd2, 32'd2);
    push_one(32'd3, 32'd3);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, mul_start, count, in_ready, out_valid, mul_mcand, mul_mlier, out_prodt} !==
        {1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 64'd0}) begin
      bad++;
      $display("FAIL midreset_clear got busy=%b start=%b count=%0d in_ready=%b valid=%b mcand=%0d prodt=%0d want 0 0 0 1 0 0 0",
               busy, mul_start, count, in_ready, out_valid, mul_mcand, out_prodt);
    end
    tick();
    reset = 1'b1;
    tick();
    push_one(32'd7, 32'd9);
    seen = 0;
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    total++;
    if ({out_valid, out_prodt} !== {1'b1, 64'd63}) begin
      bad++;
      $display("FAIL midreset_result got valid=%b prodt=%0d want 1 63", out_valid, out_prodt);
    end
    tick();
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midreset_stale got %0d extra results want 0", seen);
    end
  endtask

`ifdef ARRAY_MUL_CTRL_TAG_EN
  task automatic test_tag();
    logic [63:0] exp_p [2];
    logic [3:0]  exp_t [2];
    int got;
    exp_p[0] = 64'd4;  exp_t[0] = 4'hA;
    exp_p[1] = 64'd16; exp_t[1] = 4'h3;
    out_ready = 1'b1;
    in_tag = 4'hA;
    push_one(32'd2, 32'd2);
    in_tag = 4'h3;
    push_one(32'd4, 32'd4);
    in_tag = 4'h0;
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (out_valid) begin
        total++;
        if ({out_tag, out_prodt} !== {exp_t[got], exp_p[got]}) begin
          bad++;
          $display("FAIL tag%0d got tag=%h prodt=%0d want tag=%h prodt=%0d",
                   got, out_tag, out_prodt, exp_t[got], exp_p[got]);
        end
        got++;
      end
      tick();
    end
    total++;
    if (got != 2) begin
      bad++;
      $display("FAIL tag_count got=%0d want=2", got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_max_operands();
    test_stall();
    test_full();
    test_simultaneous();
    test_reset_mid();
`ifdef ARRAY_MUL_CTRL_TAG_EN
    test_tag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
